i2s_tx_sched: RTL

I2S_TX_SCHED -- requirements
Module: i2s_tx_sched

---
 rtl/i2s_pkg.sv | 12 +
 rtl/i2s_tx_sched_if.sv | 24 ++
 rtl/i2s_clk_div.sv | 49 ++++
 rtl/i2s_tx_sched.sv | 116 +++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit scheduler: frame geometry and FSM encoding.
package i2s_pkg;
  localparam int WIDTH_DEF    = 24;
  localparam int BCLK_DIV_DEF = 4;
  localparam int SLOT_BITS    = 32;
  localparam int FRAME_BITS   = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/i2s_tx_sched_if.sv
// Sample handshake plus I2S serial lines between a sample source and the scheduler.
interface i2s_tx_sched_if
  import i2s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             s_valid;
  logic [WIDTH-1:0] s_left;
  logic [WIDTH-1:0] s_right;
  logic             s_ready;
  logic             i2s_bclk;
  logic             i2s_wclk;
  logic             i2s_sdata;

  modport master (
    output s_valid, s_left, s_right,
    input  s_ready, i2s_bclk, i2s_wclk, i2s_sdata
  );

  modport slave (
    input  s_valid, s_left, s_right,
    output s_ready, i2s_bclk, i2s_wclk, i2s_sdata
  );
endinterface

// File: rtl/i2s_clk_div.sv
// Bit-clock divider and frame bit counter; bclk/wclk are registered copies of the next counts.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = BCLK_DIV_DEF
)(
  input  logic adc_clk,
  input  logic adc_rst_n,
  input  logic run,
  output logic tick,
  output logic frame_end,
  output logic bclk,
  output logic wclk
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [5:0]    BIT_LAST = 6'(FRAME_BITS - 1);

  logic [DW-1:0] div_cnt, div_nxt;
  logic [5:0]    bit_cnt, bit_nxt;

  assign tick      = run && (div_cnt == DIV_LAST);
  assign frame_end = tick && (bit_cnt == BIT_LAST);

  always_comb begin
    div_nxt = '0;
    bit_nxt = '0;
    if (run) begin
      div_nxt = tick ? '0 : div_cnt + 1'b1;
      bit_nxt = tick ? bit_cnt + 6'd1 : bit_cnt;
    end
  end

  // Registering from the next-state values keeps bclk/wclk aligned with the counters
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      wclk    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      bclk    <= (div_nxt >= DIV_HALF);
      wclk    <= bit_nxt[5];
    end
  end
endmodule

// File: rtl/i2s_tx_sched.sv
// I2S stereo transmitter: one-entry sample buffer, frame loader with bypass/underrun, serializer.
module i2s_tx_sched
  import i2s_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF
)(
  input  logic           adc_clk,
  input  logic           adc_rst_n,
  input  logic           en,
  i2s_tx_sched_if.slave  bus,
  output logic           frame_start,
  output logic           underrun,
  output logic [15:0]    underrun_cnt,
  output logic           busy
);
  // Zero padding after each word in its slot; WIDTH must stay <= SLOT_BITS-2
  localparam int PAD = SLOT_BITS - 1 - WIDTH;

  state_t                state;
  logic                  run, tick, frame_end, load, xfer, starve;
  logic                  buf_full, s_ready, sdata, bclk, wclk;
  logic [WIDTH-1:0]      buf_l, buf_r, src_l, src_r;
  logic [FRAME_BITS-1:0] frame, sh;

  assign run    = (state == ST_RUN);
  // A frame end with en low retires to IDLE without loading a new frame
  assign load   = en && ((state == ST_IDLE) || frame_end);
  assign xfer   = bus.s_valid && s_ready;
  assign starve = !buf_full && !bus.s_valid;

  always_comb begin
    src_l = '0;
    src_r = '0;
    if (buf_full) begin
      src_l = buf_l;
      src_r = buf_r;
    end else if (bus.s_valid) begin
      src_l = bus.s_left;
      src_r = bus.s_right;
    end
  end

  // Bit k of the frame sits at frame[63-k]; bit 0 of each slot is the I2S delay bit
  assign frame = {1'b0, src_l, {PAD{1'b0}}, 1'b0, src_r, {PAD{1'b0}}};

  i2s_clk_div #(.BCLK_DIV(BCLK_DIV)) u_div (
    .adc_clk   (adc_clk),
    .adc_rst_n (adc_rst_n),
    .run       (run),
    .tick      (tick),
    .frame_end (frame_end),
    .bclk      (bclk),
    .wclk      (wclk)
  );

  assign bus.s_ready   = s_ready;
  assign bus.i2s_bclk  = bclk;
  assign bus.i2s_wclk  = wclk;
  assign bus.i2s_sdata = sdata;

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      buf_full     <= 1'b0;
      buf_l        <= '0;
      buf_r        <= '0;
      s_ready      <= 1'b1;
      sh           <= '0;
      sdata        <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      frame_start <= load;
      underrun    <= load && starve;
      if (load && starve && (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 16'd1;

      case (state)
        ST_IDLE: if (en) begin
          state <= ST_RUN;
          busy  <= 1'b1;
        end
        ST_RUN: if (frame_end && !en) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // An offer on an empty-buffer load is consumed by the bypass, never buffered
      if (load && buf_full) begin
        buf_full <= 1'b0;
        s_ready  <= 1'b1;
      end else if (xfer && !load) begin
        buf_l    <= bus.s_left;
        buf_r    <= bus.s_right;
        buf_full <= 1'b1;
        s_ready  <= 1'b0;
      end

      if (load)
        sh <= frame;
      else if (tick)
        sh <= {sh[FRAME_BITS-2:0], 1'b0};

      if (tick)
        sdata <= frame_end ? 1'b0 : sh[FRAME_BITS-2];
    end
  end
endmodule
